// File: rtl/v850_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the V850 core: owns the PC, pulses stage enables, handles interrupts, traps and HALT.
// Optional memory-wait timeout is enabled by defining V850_BUS_TIMEOUT_EN.
module v850_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR    = 32'h0000_0060,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        dec_len32,
    input  logic        dec_is_mem,
    input  logic        dec_is_halt,
    input  logic        dec_illegal,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        int_req,
    input  logic [31:0] int_vec,
    input  logic        psw_id,
    output logic [31:0] pc,
    output logic        dec_en,
    output logic        exe_en,
    output logic        wb_en,
    output logic [31:0] save_pc,
    output logic        int_ack,
    output logic        trap,
    output logic        halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [31:0] RESET_PC_FIX = {{6{RESET_PC[25]}}, RESET_PC[25:1], 1'b0};

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] save_q, save_d;
    logic        imem_req_q, imem_req_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dec_en_q, dec_en_d;
    logic        exe_en_q, exe_en_d;
    logic        wb_en_q, wb_en_d;
    logic        int_ack_q, int_ack_d;
    logic        trap_q, trap_d;
    logic        halted_q, halted_d;

    logic [31:0] inc, seq_raw, np_raw, np_fix, vec_fix;
    logic        int_take;
    logic        timeout;
    logic        wait_inc;
    logic        unused_pc_bits;

    assign inc      = dec_len32 ? 32'd4 : 32'd2;
    assign seq_raw  = pc_q + inc;
    assign int_take = int_req & ~psw_id;

    // Raw next PC before the bit-0 clear / bit-25 sign extension rule.
    always_comb begin
        np_raw = seq_raw;
        case (state_q)
            S_TRAP:  np_raw = TRAP_VECTOR;
            S_WB:    np_raw = br_taken ? br_target : seq_raw;
            default: np_raw = seq_raw;
        endcase
    end

    assign np_fix  = {{6{np_raw[25]}}, np_raw[25:1], 1'b0};
    assign vec_fix = {{6{int_vec[25]}}, int_vec[25:1], 1'b0};
    assign unused_pc_bits = ^{np_raw[31:26], np_raw[0], int_vec[31:26], int_vec[0]};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        save_d     = save_q;
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        dec_en_d   = 1'b0;
        exe_en_d   = 1'b0;
        wb_en_d    = 1'b0;
        int_ack_d  = 1'b0;
        trap_d     = 1'b0;
        halted_d   = 1'b0;
        wait_inc   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (imem_req_q) begin
                    if (imem_ack) begin
                        state_d  = S_DECODE;
                        dec_en_d = 1'b1;
                    end else if (timeout) begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        save_d  = pc_q;
                    end else begin
                        imem_req_d = 1'b1;
                        wait_inc   = 1'b1;
                    end
                end else if (int_ack_q) begin
                    // Handler fetch starts unconditionally; a still-high level must not re-enter.
                    imem_req_d = 1'b1;
                end else if (int_take) begin
                    int_ack_d = 1'b1;
                    save_d    = pc_q;
                    pc_d      = vec_fix;
                end else begin
                    imem_req_d = 1'b1;
                end
            end

            S_DECODE: begin
                state_d  = S_EXEC;
                exe_en_d = 1'b1;
            end

            S_EXEC: begin
                if (dec_illegal) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    save_d  = pc_q;
                end else if (dec_is_halt) begin
                    // PC advances past HALT so the wake-up return address is the next instruction.
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    pc_d     = np_fix;
                end else if (dec_is_mem) begin
                    state_d    = S_MEM;
                    dmem_req_d = 1'b1;
                end else begin
                    state_d = S_WB;
                    wb_en_d = 1'b1;
                end
            end

            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                    wb_en_d = 1'b1;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    save_d  = pc_q;
                end else begin
                    dmem_req_d = 1'b1;
                    wait_inc   = 1'b1;
                end
            end

            S_WB, S_TRAP: begin
                state_d = S_FETCH;
                if (int_take) begin
                    int_ack_d = 1'b1;
                    save_d    = np_fix;
                    pc_d      = vec_fix;
                end else begin
                    pc_d       = np_fix;
                    imem_req_d = 1'b1;
                end
            end

            S_HALT: begin
                if (int_take) begin
                    state_d   = S_FETCH;
                    int_ack_d = 1'b1;
                    save_d    = pc_q;
                    pc_d      = vec_fix;
                end else begin
                    halted_d = 1'b1;
                end
            end

            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC_FIX;
            save_q     <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dec_en_q   <= 1'b0;
            exe_en_q   <= 1'b0;
            wb_en_q    <= 1'b0;
            int_ack_q  <= 1'b0;
            trap_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            save_q     <= save_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dec_en_q   <= dec_en_d;
            exe_en_q   <= exe_en_d;
            wb_en_q    <= wb_en_d;
            int_ack_q  <= int_ack_d;
            trap_q     <= trap_d;
            halted_q   <= halted_d;
        end
    end

`ifdef V850_BUS_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TW-1:0] wait_q;

    // Counts unacknowledged request cycles; any ack or state change clears it.
    always_ff @(posedge clk) begin
        if (rst || !wait_inc) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + TW'(1);
        end
    end

    assign timeout = (wait_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = wait_inc ^ (^TIMEOUT_CYCLES);
`endif

    assign imem_req = imem_req_q;
    assign dmem_req = dmem_req_q;
    assign pc       = pc_q;
    assign dec_en   = dec_en_q;
    assign exe_en   = exe_en_q;
    assign wb_en    = wb_en_q;
    assign save_pc  = save_q;
    assign int_ack  = int_ack_q;
    assign trap     = trap_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_v850_sequencer.sv
// Self-checking bench for v850_sequencer: directed vector table, hand-written HALT/reset/timeout sequences,
// and randomized instructions checked against a per-instruction cycle/PC model.
module tb_v850_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic        dmem_req, dmem_ack;
    logic        dec_len32, dec_is_mem, dec_is_halt, dec_illegal;
    logic        br_taken;
    logic [31:0] br_target;
    logic        int_req;
    logic [31:0] int_vec;
    logic        psw_id;
    logic [31:0] pc;
    logic        dec_en, exe_en, wb_en;
    logic [31:0] save_pc;
    logic        int_ack, trap, halted;

    always #5 clk = ~clk;

    v850_sequencer #(
        .RESET_PC(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0060),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .dec_len32(dec_len32), .dec_is_mem(dec_is_mem), .dec_is_halt(dec_is_halt), .dec_illegal(dec_illegal),
        .br_taken(br_taken), .br_target(br_target),
        .int_req(int_req), .int_vec(int_vec), .psw_id(psw_id),
        .pc(pc), .dec_en(dec_en), .exe_en(exe_en), .wb_en(wb_en),
        .save_pc(save_pc), .int_ack(int_ack), .trap(trap), .halted(halted)
    );

    typedef struct {
        logic        len32, is_mem, illegal, br, irq, psw;
        logic [31:0] tgt, ivec;
        int unsigned iw, dw;
        int unsigned cycles, ireq, dreq, wb, traps, acks;
        logic [31:0] end_pc, trap_save, ack_save;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          abort    = 1'b0;
    bit          noise    = 1'b0;
    logic [31:0] cur_pc;

    function automatic logic [31:0] pc_rule(input logic [31:0] a);
        return {{6{a[25]}}, a[25:1], 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic len32, is_mem, illegal, br, input logic [31:0] tgt,
                                 input int unsigned iw, dw, input logic irq, psw, input logic [31:0] ivec,
                                 input int unsigned cycles, ireq, dreq, wb, traps, acks,
                                 input logic [31:0] end_pc, trap_save, ack_save);
        vec_t v;
        v.len32 = len32; v.is_mem = is_mem; v.illegal = illegal; v.br = br; v.tgt = tgt;
        v.iw = iw; v.dw = dw; v.irq = irq; v.psw = psw; v.ivec = ivec;
        v.cycles = cycles; v.ireq = ireq; v.dreq = dreq; v.wb = wb; v.traps = traps; v.acks = acks;
        v.end_pc = end_pc; v.trap_save = trap_save; v.ack_save = ack_save;
        return v;
    endfunction

    // Instruction-level expectations: stage cycle counts, next PC and interrupt boundary behaviour.
    function automatic vec_t model(input vec_t v, input logic [31:0] pc0);
        vec_t r;
        logic [31:0] np;
        r        = v;
        r.ireq   = v.iw + 1;
        r.dreq   = (v.is_mem && !v.illegal) ? v.dw + 1 : 0;
        r.wb     = v.illegal ? 0 : 1;
        r.traps  = v.illegal ? 1 : 0;
        r.cycles = r.ireq + 2 + r.dreq + 1;
        if (v.illegal)  np = pc_rule(32'h0000_0060);
        else if (v.br)  np = pc_rule(v.tgt);
        else            np = pc_rule(pc0 + (v.len32 ? 32'd4 : 32'd2));
        r.trap_save = pc0;
        if (v.irq && !v.psw) begin
            r.acks     = 1;
            r.cycles   = r.cycles + 1;
            r.ack_save = np;
            r.end_pc   = pc_rule(v.ivec);
        end else begin
            r.acks     = 0;
            r.ack_save = '0;
            r.end_pc   = np;
        end
        return r;
    endfunction

    // Entered at a negedge where the instruction's first fetch-request cycle is visible;
    // returns at the negedge where the next fetch request appears.
    task automatic run_instr(input vec_t v, input string tag);
        int unsigned cyc = 0, ireq = 0, dreq = 0, wbn = 0, trn = 0, ackn = 0, den = 0, een = 0;
        int unsigned iseen = 0, dseen = 0;
        bit gap = 1'b0, pc_bad = 1'b0;
        logic [31:0] tsave = '0, asave = '0;
        dec_len32 = v.len32; dec_is_mem = v.is_mem; dec_illegal = v.illegal; dec_is_halt = 1'b0;
        br_taken = v.br; br_target = v.tgt;
        int_req = v.irq; psw_id = v.psw; int_vec = v.ivec;
        while (1) begin
            if (cyc > 0 && gap && imem_req) break;
            if (cyc >= 64) begin
                chk({tag, " cycle_bound"}, cyc, v.cycles);
                abort = 1'b1;
                return;
            end
            if (imem_req) begin
                ireq++;
                if (pc !== cur_pc) pc_bad = 1'b1;
                imem_ack = (iseen == v.iw);
                iseen++;
            end else begin
                if (cyc > 0) gap = 1'b1;
                imem_ack = noise ? 1'($urandom % 2) : 1'b0;
            end
            if (dmem_req) begin
                dreq++;
                dmem_ack = (dseen == v.dw);
                dseen++;
            end else begin
                dmem_ack = noise ? 1'($urandom % 2) : 1'b0;
            end
            if (wb_en)  wbn++;
            if (dec_en) den++;
            if (exe_en) een++;
            if (trap) begin trn++; tsave = save_pc; end
            if (int_ack) begin ackn++; asave = save_pc; int_req = 1'b0; end
            @(negedge clk);
            cyc++;
        end
        chk({tag, " cycles"}, cyc, v.cycles);
        chk({tag, " fetch_pc_stable"}, pc_bad, 0);
        chk({tag, " imem_req_cycles"}, ireq, v.ireq);
        chk({tag, " dmem_req_cycles"}, dreq, v.dreq);
        chk({tag, " wb_en_pulses"}, wbn, v.wb);
        chk({tag, " dec_en_pulses"}, den, 1);
        chk({tag, " exe_en_pulses"}, een, 1);
        chk({tag, " trap_pulses"}, trn, v.traps);
        chk({tag, " int_ack_pulses"}, ackn, v.acks);
        chk({tag, " next_pc"}, pc, v.end_pc);
        if (v.traps != 0) chk({tag, " trap_save_pc"}, tsave, v.trap_save);
        if (v.acks != 0)  chk({tag, " int_save_pc"}, asave, v.ack_save);
        cur_pc = v.end_pc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[16];
        vec_t rv;
        int unsigned n;
        bit bad;

        //          len mem ill br  tgt            iw dw irq psw ivec          cyc ireq dreq wb tr ack end_pc          trap_save     ack_save
        tbl[0]  = mkv(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          4, 1, 0, 1, 0, 0, 32'h0000_0002, 32'h0,        32'h0);
        tbl[1]  = mkv(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          4, 1, 0, 1, 0, 0, 32'h0000_0006, 32'h0,        32'h0);
        tbl[2]  = mkv(0, 1, 0, 0, 32'h0,          0, 3, 0, 0, 32'h0,          8, 1, 4, 1, 0, 0, 32'h0000_0008, 32'h0,        32'h0);
        tbl[3]  = mkv(1, 1, 0, 0, 32'h0,          2, 0, 0, 0, 32'h0,          7, 3, 1, 1, 0, 0, 32'h0000_000C, 32'h0,        32'h0);
        tbl[4]  = mkv(0, 0, 0, 1, 32'h0200_0000,  0, 0, 0, 0, 32'h0,          4, 1, 0, 1, 0, 0, 32'hFE00_0000, 32'h0,        32'h0);
        tbl[5]  = mkv(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          4, 1, 0, 1, 0, 0, 32'hFE00_0004, 32'h0,        32'h0);
        tbl[6]  = mkv(0, 0, 0, 1, 32'h0000_0101,  0, 0, 0, 0, 32'h0,          4, 1, 0, 1, 0, 0, 32'h0000_0100, 32'h0,        32'h0);
        tbl[7]  = mkv(0, 1, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,          4, 1, 0, 0, 1, 0, 32'h0000_0060, 32'h100,      32'h0);
        tbl[8]  = mkv(0, 0, 0, 0, 32'h0,          0, 0, 1, 1, 32'h500,        4, 1, 0, 1, 0, 0, 32'h0000_0062, 32'h0,        32'h0);
        tbl[9]  = mkv(1, 0, 0, 0, 32'h0,          0, 0, 1, 0, 32'h201,        5, 1, 0, 1, 0, 1, 32'h0000_0200, 32'h0,        32'h66);
        tbl[10] = mkv(0, 0, 1, 0, 32'h0,          0, 0, 1, 0, 32'h300,        5, 1, 0, 0, 1, 1, 32'h0000_0300, 32'h200,      32'h60);
        tbl[11] = mkv(0, 0, 0, 1, 32'h01FF_FFFE,  1, 0, 0, 0, 32'h0,          5, 2, 0, 1, 0, 0, 32'h01FF_FFFE, 32'h0,        32'h0);
        tbl[12] = mkv(0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          4, 1, 0, 1, 0, 0, 32'hFE00_0000, 32'h0,        32'h0);
        tbl[13] = mkv(0, 0, 0, 1, 32'hFFFF_FFFE,  0, 0, 0, 0, 32'h0,          4, 1, 0, 1, 0, 0, 32'hFFFF_FFFE, 32'h0,        32'h0);
        tbl[14] = mkv(1, 0, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,          4, 1, 0, 1, 0, 0, 32'h0000_0002, 32'h0,        32'h0);
        tbl[15] = mkv(0, 1, 0, 1, 32'h0000_0040,  0, 1, 0, 0, 32'h0,          6, 1, 2, 1, 0, 0, 32'h0000_0040, 32'h0,        32'h0);

        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        dec_len32 = 1'b0; dec_is_mem = 1'b0; dec_is_halt = 1'b0; dec_illegal = 1'b0;
        br_taken = 1'b0; br_target = '0; int_req = 1'b0; int_vec = '0; psw_id = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {imem_req, dmem_req, dec_en, exe_en, wb_en, int_ack, trap, halted}, 8'h00);
        chk("reset_pc", pc, 32'h0);
        chk("reset_save_pc", save_pc, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_imem_req", imem_req, 1);
        cur_pc = 32'h0;

        for (int i = 0; i < 16; i++) begin
            if (!abort) run_instr(tbl[i], $sformatf("vec%0d", i));
        end

        // HALT at 0x40, masked interrupt, then wake-up
        if (!abort) begin
            chk("halt_start_pc", pc, 32'h40);
            dec_is_halt = 1'b1; dec_len32 = 1'b0; dec_is_mem = 1'b0; dec_illegal = 1'b0;
            br_taken = 1'b0; int_req = 1'b0; psw_id = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b0;
            n = 0;
            while (n < 16) begin
                @(negedge clk);
                n++;
                imem_ack = 1'b0;
                if (halted) break;
            end
            chk("halt_entry_cycles", n, 3);
            int_req = 1'b1; psw_id = 1'b1; int_vec = 32'h0000_0480;
            bad = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (!halted || int_ack || imem_req) bad = 1'b1;
            end
            chk("halt_masked_stays", bad, 0);
            psw_id = 1'b0;
            @(negedge clk);
            chk("halt_wake_int_ack", int_ack, 1);
            chk("halt_wake_halted", halted, 0);
            chk("halt_wake_save_pc", save_pc, 32'h42);
            chk("halt_wake_pc", pc, 32'h480);
            int_req = 1'b0; dec_is_halt = 1'b0;
            @(negedge clk);
            chk("handler_fetch_req", imem_req, 1);
            chk("handler_fetch_pc", pc, 32'h480);
            cur_pc = 32'h480;
        end

        // Reset during an outstanding fetch
        if (!abort) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk("wait_req_held", imem_req, 1);
            chk("wait_pc_held", pc, 32'h480);
            rst = 1'b1;
            @(negedge clk);
            chk("rst_drops_req", imem_req, 0);
            chk("rst_pc", pc, 32'h0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("rst_release_req", imem_req, 1);
            chk("rst_release_pc", pc, 32'h0);
            cur_pc = 32'h0;
        end

`ifdef V850_BUS_TIMEOUT_EN
        // Fetch never acknowledged
        if (!abort) begin
            int unsigned reqc = 0;
            bit seen = 1'b0;
            logic [31:0] tsv = '0;
            imem_ack = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (imem_req) reqc++;
                if (trap) begin seen = 1'b1; tsv = save_pc; break; end
                @(negedge clk);
            end
            chk("timeout_req_cycles", reqc, 4);
            chk("timeout_trap_seen", seen, 1);
            chk("timeout_save_pc", tsv, 32'h0);
            @(negedge clk);
            chk("timeout_refetch_req", imem_req, 1);
            chk("timeout_refetch_pc", pc, 32'h60);
            cur_pc = 32'h60;
        end
`endif

        noise = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if (abort) break;
            rv.len32   = 1'($urandom % 2);
            rv.is_mem  = 1'($urandom % 2);
            rv.illegal = ($urandom % 8) == 0;
            rv.br      = ($urandom % 4) == 0;
            rv.tgt     = $urandom;
            rv.iw      = $urandom_range(0, 3);
            rv.dw      = $urandom_range(0, 3);
            rv.irq     = ($urandom % 4) == 0;
            rv.psw     = 1'($urandom % 2);
            rv.ivec    = $urandom;
            rv = model(rv, cur_pc);
            run_instr(rv, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
